mult_vector_checker: RTL
========================

Name: mult_vector_checker

Overview:
- Self-checking stimulus/response stage wrapped around the combinational `multiplier` (ports A, B, P).
- Sits upstream of the multiplier, driving A and B, and downstream of it, consuming P.
- Generates a seeded pseudo-random operand sequence and waits a programmable settle time before sampling the product.
- Compares each product against an internal golden A*B and accumulates pass/error statistics, so exploration runs are graded in hardware or simulation without text-output parsing.

Parameters:
- WIDTH, 2, operand width; legal range 1..8.
- NUM_VECTORS, 20, vectors per run; legal range 1..65535.
- SETTLE_CYCLES, 1, cycles operands are held before P is checked; legal range ≥1.
- SEED, 16'hACE1, LFSR start value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled only in IDLE or DONE.
- mult_a  out  WIDTH  operand A to multiplier.
- mult_b  out  WIDTH  operand B to multiplier.
- mult_p  in  2*WIDTH  product P from multiplier.
- busy  out  1  high in SETTLE/CHECK.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count==0.
- vec_count  out  16  vectors checked this run.
- err_count  out  16  mismatches this run; saturates at 16'hFFFF.
- mismatch_valid  out  1  one-cycle pulse per mismatch.
- mismatch_p  out  2*WIDTH  captured mult_p on mismatch.
- mismatch_exp  out  2*WIDTH  captured expected product on mismatch.

Behaviour:
- Reset (asynchronous, immediate) forces:
  - state IDLE;
  - all outputs 0;
  - LFSR = SEED (with the 0 substitution).
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shift right; XOR the mask when the shifted-out bit is 1.
  - Advances exactly once per vector, on the edge leaving CHECK.
- Operands loaded on entering SETTLE: mult_a = lfsr[WIDTH-1:0], mult_b = lfsr[2*WIDTH-1:WIDTH].
- Expected product = mult_a*mult_b, computed at full 2*WIDTH width (unsigned, no truncation).
- mult_a/mult_b stay stable from SETTLE entry through the CHECK edge.
- FSM states:
  - IDLE: on start=1, clear vec_count/err_count/pass, reload LFSR from SEED, load operands, go to SETTLE with settle_cnt=SETTLE_CYCLES.
  - SETTLE: settle_cnt decrements each cycle; go to CHECK on the edge where settle_cnt==1.
  - CHECK: compare mult_p with expected on this edge; vec_count += 1.
    - On mismatch: err_count += 1 (saturating); mismatch_valid=1 for the next cycle only; capture mismatch_p and mismatch_exp.
    - If vec_count+1==NUM_VECTORS, go to DONE and set pass=(final err_count==0).
    - Otherwise advance the LFSR, load new operands, go to SETTLE.
  - DONE: done=1, pass valid, counters held; start=1 restarts exactly as from IDLE (done drops on the next edge).
- Timing:
  - Per-vector cost is SETTLE_CYCLES+1 edges.
  - done rises on edge NUM_VECTORS*(SETTLE_CYCLES+1) counted from the start-sampling edge, which is edge 0.
  - Defaults: done rises at edge 40.
- start while busy is ignored; it neither restarts nor extends the run.
- mismatch_p and mismatch_exp hold the most recent mismatch until the next mismatch, restart, or reset.
- Reset asserted mid-run aborts immediately. The next run after reset replays the identical operand sequence.
- Same SEED always produces the same sequence, which makes runs reproducible across design points.

Test Plan:
- Correct multiplier, defaults, start pulse → done at edge 40; vec_count=20; err_count=0; pass=1; mismatch_valid never asserts.
- Faulty multiplier (P = A*B XOR 1) → err_count=20, pass=0, exactly 20 mismatch_valid pulses; last capture has mismatch_p == mismatch_exp^1.
- P stuck at 0 → err_count equals the number of vectors with both operands nonzero, per the golden LFSR model; pass=0.
- rst_n low during vector 7 → all outputs 0 within the same cycle; a subsequent start reproduces operand pairs 0..6 bit-exactly.
- start held high for the whole run → no restart, done at edge 40. start in DONE → counters clear, done drops, identical second run.
- SETTLE_CYCLES=3, WIDTH=4, NUM_VECTORS=5, correct multiplier → done at edge 20, pass=1, operands stable 3 cycles before each check.

Source files
------------

// File: rtl/mult_vector_checker.sv
// Stimulus/response wrapper for a combinational multiplier: drives LFSR operands,
// waits a settle time, grades P against a golden A*B and keeps run statistics.
module mult_vector_checker #(
  parameter int          WIDTH         = 2,
  parameter int          NUM_VECTORS   = 20,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_p,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          vec_count,
  output logic [15:0]          err_count,
  output logic                 mismatch_valid,
  output logic [2*WIDTH-1:0]   mismatch_p,
  output logic [2*WIDTH-1:0]   mismatch_exp
);

  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam int          CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);
  localparam logic [15:0] NUM_VEC     = 16'(NUM_VECTORS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CW-1:0]        settle_q, settle_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [15:0]          vec_q, vec_d;
  logic [15:0]          err_q, err_d;
  logic                 pass_q, pass_d;
  logic                 mv_q, mv_d;
  logic [2*WIDTH-1:0]   mp_q, mp_d;
  logic [2*WIDTH-1:0]   mexp_q, mexp_d;

  logic [2*WIDTH-1:0]   expected;
  logic [15:0]          lfsr_adv;
  logic [15:0]          vec_inc;
  logic [15:0]          err_final;
  logic                 is_mismatch;

  // Galois right-shift step: fold the mask in when a 1 falls out of bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = {1'b0, s[15:1]};
    return s[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    vec_d    = vec_q;
    err_d    = err_q;
    pass_d   = pass_q;
    mv_d     = 1'b0;
    mp_d     = mp_q;
    mexp_d   = mexp_q;

    expected    = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
    lfsr_adv    = lfsr_step(lfsr_q);
    vec_inc     = vec_q + 16'd1;
    is_mismatch = (mult_p != expected);
    err_final   = err_q;
    if (is_mismatch && (err_q != '1)) begin
      err_final = err_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          mp_d     = '0;
          mexp_d   = '0;
          lfsr_d   = SEED_EFF;
          a_d      = SEED_EFF[WIDTH-1:0];
          b_d      = SEED_EFF[2*WIDTH-1:WIDTH];
          settle_d = SETTLE_INIT;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - CW'(1);
        if (settle_q == CW'(1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        vec_d = vec_inc;
        err_d = err_final;
        if (is_mismatch) begin
          mv_d   = 1'b1;
          mp_d   = mult_p;
          mexp_d = expected;
        end
        if (vec_inc == NUM_VEC) begin
          pass_d  = (err_final == '0);
          state_d = S_DONE;
        end else begin
          lfsr_d   = lfsr_adv;
          a_d      = lfsr_adv[WIDTH-1:0];
          b_d      = lfsr_adv[2*WIDTH-1:WIDTH];
          settle_d = SETTLE_INIT;
          state_d  = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      mv_q     <= 1'b0;
      mp_q     <= '0;
      mexp_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      mv_q     <= mv_d;
      mp_q     <= mp_d;
      mexp_q   <= mexp_d;
    end
  end

  assign mult_a         = a_q;
  assign mult_b         = b_q;
  assign busy           = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign mismatch_valid = mv_q;
  assign mismatch_p     = mp_q;
  assign mismatch_exp   = mexp_q;

endmodule
